// File: rtl/sram_bist.sv
// sram_bist: start/done SRAM built-in self-test engine.
// Writes and then reads back a selectable data pattern over a runtime address
// window, handshaking with the SRAM controller (req/ready for requests,
// one-cycle valid strobe for read data). Reports the error count and the
// details of the first mismatch, and can optionally stop at the first error.
module sram_bist #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int ERR_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDR_BITS-1:0]    addr_lo,
    input  logic [ADDR_BITS-1:0]    addr_hi,
    input  logic                    stop_on_error,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_CNT_BITS-1:0] err_count,
    output logic [ADDR_BITS-1:0]    first_err_addr,
    output logic [DATA_BITS-1:0]    first_err_expected,
    output logic [DATA_BITS-1:0]    first_err_actual,
    output logic [4:0]              phase,
    output logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    mem_write_enable,
    output logic [ADDR_BITS-1:0]    mem_addr,
    output logic [DATA_BITS-1:0]    mem_write_data,
    input  logic [DATA_BITS-1:0]    mem_read_data,
    input  logic                    mem_read_data_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_ADDR,
        P_CHK,
        P_WALK
    } pat_kind_t;

    // Alternating pattern with the MSB set: 1010...
    function automatic logic [DATA_BITS-1:0] chk_pattern();
        logic [DATA_BITS-1:0] v;
        for (int i = 0; i < DATA_BITS; i++) begin
            v[i] = ((DATA_BITS - 1 - i) % 2) == 0;
        end
        return v;
    endfunction

    localparam logic [DATA_BITS-1:0] CHK_HI    = chk_pattern();
    localparam logic [DATA_BITS-1:0] ONE_HOT0  = {{(DATA_BITS-1){1'b0}}, 1'b1};
    localparam logic [4:0]           LAST_WALK = 5'(DATA_BITS - 1);
    localparam logic [4:0]           LAST_ALL  = 5'(DATA_BITS + 2);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_BITS-1:0]    r_lo;
    logic [ADDR_BITS-1:0]    r_hi;
    logic [ADDR_BITS-1:0]    r_addr;
    logic                    r_stop;
    logic [1:0]              r_mode;
    logic                    r_bad_window;
    logic [4:0]              r_phase;
    logic [DATA_BITS-1:0]    r_expected;
    logic [ERR_CNT_BITS-1:0] r_err_count;
    logic [ADDR_BITS-1:0]    r_first_addr;
    logic [DATA_BITS-1:0]    r_first_exp;
    logic [DATA_BITS-1:0]    r_first_act;

    logic                    w_mem_req;
    logic                    w_mem_we;
    logic                    w_hs;
    logic                    w_start_accept;
    logic                    w_at_hi;
    logic                    w_last_phase;
    logic                    w_mismatch;
    pat_kind_t               w_kind;
    logic                    w_chk_inv;
    logic [4:0]              w_walk_bit;
    logic [4:0]              w_last_idx;
    logic [DATA_BITS-1:0]    w_chk;
    logic [DATA_BITS-1:0]    w_pattern;

    assign w_start_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_hs           = w_mem_req && mem_ready;
    assign w_at_hi        = (r_addr == r_hi);
    assign w_last_phase   = (r_phase == w_last_idx);
    assign w_mismatch     = (r_state == S_READ_WAIT) && mem_read_data_valid &&
                            (mem_read_data != r_expected);

    // Decode the global phase index into a pattern kind for the latched mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_kind     = P_ADDR;
        w_chk_inv  = 1'b0;
        w_walk_bit = '0;
        w_last_idx = '0;
        case (r_mode)
            2'd0: begin
                w_kind     = P_ADDR;
                w_last_idx = 5'd0;
            end
            2'd1: begin
                w_kind     = P_CHK;
                w_chk_inv  = r_phase[0];
                w_last_idx = 5'd1;
            end
            2'd2: begin
                w_kind     = P_WALK;
                w_walk_bit = r_phase;
                w_last_idx = LAST_WALK;
            end
            default: begin
                w_last_idx = LAST_ALL;
                if (r_phase == 5'd0) begin
                    w_kind = P_ADDR;
                end else if (r_phase <= 5'd2) begin
                    w_kind    = P_CHK;
                    w_chk_inv = (r_phase == 5'd2);
                end else begin
                    w_kind     = P_WALK;
                    w_walk_bit = r_phase - 5'd3;
                end
            end
        endcase
    end

    // Data pattern for the current address and phase.
    always_comb begin
        w_chk     = r_addr[0] ? CHK_HI : ~CHK_HI;
        w_pattern = '0;
        case (w_kind)
            P_ADDR:  w_pattern = DATA_BITS'(r_addr);
            P_CHK:   w_pattern = w_chk_inv ? ~w_chk : w_chk;
            P_WALK:  w_pattern = ONE_HOT0 << w_walk_bit;
            default: w_pattern = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            r_state <= w_next;
        end
    end

    // FSM next state and memory request outputs.
    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_WRITE;
            end
            S_WRITE: begin
                if (r_bad_window) begin
                    w_next = S_DONE;
                end else begin
                    w_mem_req = 1'b1;
                    w_mem_we  = 1'b1;
                    if (mem_ready && w_at_hi) w_next = S_READ_REQ;
                end
            end
            S_READ_REQ: begin
                w_mem_req = 1'b1;
                if (mem_ready) w_next = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                if (mem_read_data_valid) begin
                    if (w_mismatch && r_stop) w_next = S_DONE;
                    else if (!w_at_hi)        w_next = S_READ_REQ;
                    else if (w_last_phase)    w_next = S_DONE;
                    else                      w_next = S_WRITE;
                end
            end
            S_DONE: begin
                if (start) w_next = S_WRITE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: test configuration, address/phase walk, expected data, error capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo         <= '0;
            r_hi         <= '0;
            r_addr       <= '0;
            r_stop       <= 1'b0;
            r_mode       <= 2'd0;
            r_bad_window <= 1'b0;
            r_phase      <= '0;
            r_expected   <= '0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else if (w_start_accept) begin
            r_lo         <= addr_lo;
            r_hi         <= addr_hi;
            r_addr       <= addr_lo;
            r_stop       <= stop_on_error;
            r_mode       <= mode;
            r_bad_window <= (addr_lo > addr_hi);
            r_phase      <= '0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else begin
            case (r_state)
                S_WRITE: begin
                    if (w_hs) r_addr <= w_at_hi ? r_lo : r_addr + 1'b1;
                end
                S_READ_REQ: begin
                    if (w_hs) r_expected <= w_pattern;
                end
                S_READ_WAIT: begin
                    if (mem_read_data_valid) begin
                        if (w_mismatch) begin
                            if (r_err_count != {ERR_CNT_BITS{1'b1}}) begin
                                r_err_count <= r_err_count + 1'b1;
                            end
                            if (r_err_count == '0) begin
                                r_first_addr <= r_addr;
                                r_first_exp  <= r_expected;
                                r_first_act  <= mem_read_data;
                            end
                        end
                        if (!(w_mismatch && r_stop)) begin
                            if (w_at_hi) begin
                                r_addr <= r_lo;
                                if (!w_last_phase) r_phase <= r_phase + 5'd1;
                            end else begin
                                r_addr <= r_addr + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy               = (r_state == S_WRITE) || (r_state == S_READ_REQ) ||
                                (r_state == S_READ_WAIT);
    assign done               = (r_state == S_DONE);
    assign pass               = done && !r_bad_window && (r_err_count == '0);
    assign err_count          = r_err_count;
    assign first_err_addr     = r_first_addr;
    assign first_err_expected = r_first_exp;
    assign first_err_actual   = r_first_act;
    assign phase              = r_phase;
    assign mem_req            = w_mem_req;
    assign mem_write_enable   = w_mem_we;
    assign mem_addr           = r_addr;
    assign mem_write_data     = w_mem_we ? w_pattern : '0;

endmodule

// File: tb/tb_sram_bist.sv
// Directed testbench for sram_bist with a small SRAM controller model
// (optional ready stalls, 2-cycle read latency, optional stuck-at-0 fault).
module tb_sram_bist;

    localparam int AB = 4;
    localparam int DB = 8;
    localparam int EB = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [AB-1:0] addr_lo = '0;
    logic [AB-1:0] addr_hi = '0;
    logic          stop_on_error = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EB-1:0] err_count;
    logic [AB-1:0] first_err_addr;
    logic [DB-1:0] first_err_expected;
    logic [DB-1:0] first_err_actual;
    logic [4:0]    phase;
    logic          mem_req;
    logic          mem_ready;
    logic          mem_write_enable;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_write_data;
    logic [DB-1:0] mem_read_data;
    logic          mem_read_data_valid;

    int total = 0;
    int bad   = 0;

    // Controller model configuration (driven by the stimulus block)
    int            ready_delay = 0;
    logic          stuck_en = 1'b0;
    logic          stray_v = 1'b0;
    logic [DB-1:0] stray_d = '0;

    // Controller model state and monitor counters (written only by the model)
    logic [DB-1:0] mem [16];
    int            wait_cnt = 0;
    logic          p1_v = 1'b0;
    logic          m_v = 1'b0;
    logic [DB-1:0] p1_d = '0;
    logic [DB-1:0] m_d = '0;
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    int            req_cyc = 0;
    int            stall_cyc = 0;
    int            stab_viol = 0;
    int            req_in_done = 0;
    logic [AB-1:0] last_wr_addr = '0;
    logic          prev_stall = 1'b0;
    logic [AB-1:0] prev_addr = '0;
    logic          prev_we = 1'b0;
    logic [DB-1:0] prev_wd = '0;

    sram_bist #(
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB),
        .ERR_CNT_BITS (EB)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .mode                (mode),
        .addr_lo             (addr_lo),
        .addr_hi             (addr_hi),
        .stop_on_error       (stop_on_error),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .err_count           (err_count),
        .first_err_addr      (first_err_addr),
        .first_err_expected  (first_err_expected),
        .first_err_actual    (first_err_actual),
        .phase               (phase),
        .mem_req             (mem_req),
        .mem_ready           (mem_ready),
        .mem_write_enable    (mem_write_enable),
        .mem_addr            (mem_addr),
        .mem_write_data      (mem_write_data),
        .mem_read_data       (mem_read_data),
        .mem_read_data_valid (mem_read_data_valid)
    );

    always #5 clk = ~clk;

    assign mem_ready           = (ready_delay == 0) || (wait_cnt >= ready_delay);
    assign mem_read_data_valid = m_v | stray_v;
    assign mem_read_data       = stray_v ? stray_d : m_d;

    // SRAM controller model plus request-side monitors
    always @(posedge clk) begin
        m_v  <= p1_v;
        m_d  <= p1_d;
        p1_v <= 1'b0;
        if (mem_req && mem_ready) begin
            wait_cnt <= 0;
            if (mem_write_enable) begin
                mem[mem_addr] <= mem_write_data;
                wr_cnt        <= wr_cnt + 1;
                last_wr_addr  <= mem_addr;
            end else begin
                p1_v   <= 1'b1;
                p1_d   <= mem[mem_addr] & ((stuck_en && mem_addr == 4'd5) ? 8'hF7 : 8'hFF);
                rd_cnt <= rd_cnt + 1;
            end
        end else if (mem_req) begin
            wait_cnt  <= wait_cnt + 1;
            stall_cyc <= stall_cyc + 1;
        end
        if (mem_req) req_cyc <= req_cyc + 1;
        if (mem_req && done) req_in_done <= req_in_done + 1;
        if (prev_stall && (!mem_req || mem_addr !== prev_addr ||
                           mem_write_enable !== prev_we || mem_write_data !== prev_wd)) begin
            stab_viol <= stab_viol + 1;
        end
        prev_stall <= mem_req && !mem_ready;
        prev_addr  <= mem_addr;
        prev_we    <= mem_write_enable;
        prev_wd    <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_test(input logic [1:0] m, input logic [AB-1:0] lo,
                              input logic [AB-1:0] hi, input logic soe);
        mode          = m;
        addr_lo       = lo;
        addr_hi       = hi;
        stop_on_error = soe;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_done_in_time"}, 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_pass"},   32'(pass), 32'd0);
        check({tag, "_err"},    32'(err_count), 32'd0);
        check({tag, "_faddr"},  32'(first_err_addr), 32'd0);
        check({tag, "_fexp"},   32'(first_err_expected), 32'd0);
        check({tag, "_fact"},   32'(first_err_actual), 32'd0);
        check({tag, "_phase"},  32'(phase), 32'd0);
        check({tag, "_req"},    32'(mem_req), 32'd0);
        check({tag, "_we"},     32'(mem_write_enable), 32'd0);
        check({tag, "_addr"},   32'(mem_addr), 32'd0);
        check({tag, "_wdata"},  32'(mem_write_data), 32'd0);
    endtask

    initial begin
        int wr0, rd0, req0, st0, sv0, rid0;

        // Reset state
        #12;
        check_all_zero("reset");
        #5;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: ideal controller, mode 0, full window 0..15
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_test(2'd0, 4'd0, 4'd15, 1'b0);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_done_cleared", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("t1_req_by_2nd_cycle", 32'(mem_req), 32'd1);
        wait_done(1000, "t1");
        check("t1_writes", 32'(wr_cnt - wr0), 32'd16);
        check("t1_reads",  32'(rd_cnt - rd0), 32'd16);
        check("t1_pass",   32'(pass), 32'd1);
        check("t1_err",    32'(err_count), 32'd0);
        check("t1_busy",   32'(busy), 32'd0);
        check("t1_mem10",  32'(mem[10]), 32'h0A);

        // 2: controller holds ready low 3 cycles per request
        ready_delay = 3;
        wr0 = wr_cnt; rd0 = rd_cnt; st0 = stall_cyc; sv0 = stab_viol;
        start_test(2'd0, 4'd0, 4'd15, 1'b0);
        wait_done(2000, "t2");
        check("t2_stall_cycles", 32'(stall_cyc - st0), 32'd96);
        check("t2_stable_req",   32'(stab_viol - sv0), 32'd0);
        check("t2_writes", 32'(wr_cnt - wr0), 32'd16);
        check("t2_reads",  32'(rd_cnt - rd0), 32'd16);
        check("t2_pass",   32'(pass), 32'd1);
        check("t2_err",    32'(err_count), 32'd0);
        ready_delay = 0;

        // 3: bit 3 stuck-at-0 at address 5, walking ones, keep going
        stuck_en = 1'b1;
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_test(2'd2, 4'd0, 4'd15, 1'b0);
        wait_done(3000, "t3");
        check("t3_reads", 32'(rd_cnt - rd0), 32'd128);
        check("t3_err",   32'(err_count), 32'd1);
        check("t3_faddr", 32'(first_err_addr), 32'd5);
        check("t3_fexp",  32'(first_err_expected), 32'h08);
        check("t3_fact",  32'(first_err_actual), 32'h00);
        check("t3_pass",  32'(pass), 32'd0);
        check("t3_phase", 32'(phase), 32'd7);

        // 4: same fault, all patterns, stop on first error (checkerboard phase, 0xAA at addr 5)
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_test(2'd3, 4'd0, 4'd15, 1'b1);
        wait_done(3000, "t4");
        rid0 = req_in_done;
        repeat (10) @(posedge clk);
        #1;
        check("t4_no_req_after_done", 32'(req_in_done - rid0), 32'd0);
        check("t4_req_low", 32'(mem_req), 32'd0);
        check("t4_writes", 32'(wr_cnt - wr0), 32'd32);
        check("t4_reads",  32'(rd_cnt - rd0), 32'd22);
        check("t4_err",    32'(err_count), 32'd1);
        check("t4_faddr",  32'(first_err_addr), 32'd5);
        check("t4_fexp",   32'(first_err_expected), 32'hAA);
        check("t4_fact",   32'(first_err_actual), 32'hA2);
        check("t4_phase",  32'(phase), 32'd1);
        check("t4_pass",   32'(pass), 32'd0);
        stuck_en = 1'b0;

        // 5a: inverted window, no memory traffic
        req0 = req_cyc;
        start_test(2'd0, 4'd9, 4'd3, 1'b0);
        check("t5a_busy", 32'(busy), 32'd1);
        check("t5a_done_not_yet", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("t5a_done", 32'(done), 32'd1);
        check("t5a_pass", 32'(pass), 32'd0);
        check("t5a_err",  32'(err_count), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t5a_no_req", 32'(req_cyc - req0), 32'd0);

        // 5b: single-address window at the top of the address space
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_test(2'd0, 4'd15, 4'd15, 1'b0);
        wait_done(200, "t5b");
        check("t5b_writes", 32'(wr_cnt - wr0), 32'd1);
        check("t5b_reads",  32'(rd_cnt - rd0), 32'd1);
        check("t5b_waddr",  32'(last_wr_addr), 32'd15);
        check("t5b_pass",   32'(pass), 32'd1);

        // 6: reset in the middle of a read wait
        rd0 = rd_cnt;
        start_test(2'd0, 4'd0, 4'd15, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (rd_cnt - rd0 >= 3 && mem_req && !mem_write_enable && mem_ready) break;
            @(posedge clk);
            #1;
        end
        check("t6_read_req_seen", 32'(mem_req && !mem_write_enable), 32'd1);
        @(posedge clk);
        #2;
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        #24;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        stray_v = 1'b1;
        stray_d = 8'h5A;
        @(posedge clk);
        #1;
        stray_v = 1'b0;
        @(posedge clk);
        #1;
        check("t6_stray_err", 32'(err_count), 32'd0);
        check("t6_stray_busy", 32'(busy), 32'd0);
        check("t6_stray_done", 32'(done), 32'd0);
        wr0 = wr_cnt; rd0 = rd_cnt;
        start_test(2'd1, 4'd0, 4'd15, 1'b0);
        wait_done(2000, "t6");
        check("t6_writes", 32'(wr_cnt - wr0), 32'd32);
        check("t6_reads",  32'(rd_cnt - rd0), 32'd32);
        check("t6_pass",   32'(pass), 32'd1);
        check("t6_err",    32'(err_count), 32'd0);
        check("t6_phase",  32'(phase), 32'd1);
        check("t6_mem5",   32'(mem[5]), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_bist.md
Name: sram_bist

Overview:
- Parametrised successor to the fixed-sweep SRAM tester: a start/done SRAM built-in self-test engine.
- Writes then reads back a selectable data pattern over a runtime address window, using proper handshakes to the SRAM controller instead of fixed cycle delays.
- Reports error count and first-failure details; optionally stops on the first error.
- Sits between top-level debug/LED logic and sram_controller.

Parameters:
- ADDR_BITS, 20, SRAM address width.
- DATA_BITS, 16, SRAM data width (>=2).
- ERR_CNT_BITS, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin test; sampled only when not busy.
- mode  in  2  pattern select: 0 addr-as-data, 1 checkerboard, 2 walking-ones, 3 all of 0,1,2 in order.
- addr_lo  in  ADDR_BITS  first address of window; latched at start.
- addr_hi  in  ADDR_BITS  last address of window, inclusive; latched at start.
- stop_on_error  in  1  abort at first mismatch; latched at start.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid while done: 1 iff window valid and err_count==0.
- err_count  out  ERR_CNT_BITS  mismatches seen; saturates at all-ones.
- first_err_addr  out  ADDR_BITS  address of first mismatch.
- first_err_expected  out  DATA_BITS  expected data at first mismatch.
- first_err_actual  out  DATA_BITS  read data at first mismatch.
- phase  out  5  current pattern phase index (debug).
- mem_req  out  1  request to controller.
- mem_ready  in  1  controller accepts request this cycle when mem_req && mem_ready.
- mem_write_enable  out  1  1=write, 0=read; stable while mem_req high.
- mem_addr  out  ADDR_BITS  request address; stable while mem_req high.
- mem_write_data  out  DATA_BITS  write data; stable while mem_req high.
- mem_read_data  in  DATA_BITS  read return data.
- mem_read_data_valid  in  1  one-cycle strobe qualifying mem_read_data.

Behaviour:
- Reset: all outputs 0 (busy, done, pass, err_count, first_err_*, phase, mem_req, mem_write_enable, mem_addr, mem_write_data); FSM to IDLE. Reset mid-test abandons the test immediately; mem_req drops asynchronously.
- FSM: IDLE -> WRITE -> READ_REQ -> READ_WAIT -> (READ_REQ | next phase WRITE | DONE); DONE -> start accepted -> WRITE.
- Start accepted in IDLE or DONE: latch addr_lo/addr_hi/stop_on_error/mode, clear err_count and first_err_*, clear done/pass, phase=0, busy=1 next cycle. mem_req asserted by the second cycle after start. start while busy is ignored.
- addr_lo > addr_hi: no memory ops; DONE one cycle after busy rises, pass=0, err_count=0.
- Phase sequence:
  - mode 0: 1 phase, data = addr zero-extended/truncated to DATA_BITS.
  - mode 1: 2 phases; phase 0 data = addr[0] ? {1010..} : {0101..}; phase 1 inverted.
  - mode 2: DATA_BITS phases; phase p data = 1<<p at every address.
  - mode 3: 1+2+DATA_BITS phases run back-to-back (mode 0, then 1, then 2); phase output counts 0..DATA_BITS+2.
- Each phase: write addr_lo..addr_hi ascending, then read addr_lo..addr_hi ascending.
- WRITE: mem_req=1, we=1. On handshake, advance address; back-to-back writes allowed (next request valid the cycle after acceptance). After handshake at addr_hi, go to READ_REQ at addr_lo.
- READ_REQ: mem_req=1, we=0 until handshake, then READ_WAIT with mem_req=0. Exactly one read outstanding.
- READ_WAIT: on mem_read_data_valid, compare with the registered expected value.
  - Mismatch: err_count += 1, saturating. If err_count was 0, capture first_err_addr/expected/actual. Compare may be pipelined one cycle; the next action waits for it.
  - Mismatch with stop_on_error=1: go to DONE.
  - Otherwise: at addr_hi, go to next phase's WRITE, or DONE after the last phase; else READ_REQ at addr+1.
- mem_read_data_valid outside READ_WAIT is ignored.
- Last-address detection uses equality with addr_hi, never counter overflow. addr_hi = 2^ADDR_BITS-1 must not wrap.
- DONE: busy=0, done=1, pass=(err_count==0), mem_req=0. Outputs hold until next start or reset.

Test Plan:
- ADDR_BITS=4, ideal SRAM model (ready=1, valid 2 cycles after read), mode=0, window 0..15 -> 16 writes then 16 reads; done with pass=1, err_count=0.
- Controller model with ready low for 3 cycles per request -> mem_addr/we/data stable while mem_req && !ready; final result identical to the ideal case.
- Bit 3 stuck-at-0 at address 5, mode=2, DATA_BITS=8, stop_on_error=0 -> err_count=1, first_err_addr=5, expected=0x08, actual=0x00, pass=0.
- Same fault, mode=3, stop_on_error=1 -> DONE right after the first mismatch; no mem_req afterwards; err_count=1.
- addr_lo=9, addr_hi=3 -> no mem_req ever; done=1, pass=0. Window 15..15 with ADDR_BITS=4 -> single address tested, no wrap to 0.
- reset_n pulsed low mid-READ_WAIT -> all outputs 0 immediately. A new start runs a full clean test with pass=1; stray mem_read_data_valid during IDLE causes no error.
